// File: rtl/countdown8.sv
// Programmable 8-bit down-counting timer with a valid/ready period load.
// It counts to zero, pulses expire on each rollover, and then either stops or reloads.
module countdown8 #(
    parameter bit RELOAD_DEFAULT = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_value,
    input  logic       auto_reload,
    input  logic       pause,
    input  logic       abort,
    output logic [7:0] count,
    output logic       busy,
    output logic       expire,
    output logic [7:0] expire_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] period_m1;
    logic       reload_flag;

    // Both handshake outputs decode the state register directly, so no input reaches them.
    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // NOTE: every register in this block uses non-blocking assignment, so all next-state terms read the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            period_m1    <= 8'd0;
            count        <= 8'd0;
            reload_flag  <= RELOAD_DEFAULT;
            expire       <= 1'b0;
            expire_count <= 8'd0;
        end else begin
            expire <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_valid && !abort) begin
                        // A value of 0 wraps to 255, which gives a period of 256.
                        period_m1    <= load_value - 8'd1;
                        count        <= load_value - 8'd1;
                        reload_flag  <= auto_reload;
                        expire_count <= 8'd0;
                        state        <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (abort) begin
                        state <= IDLE;
                        count <= 8'd0;
                    end else if (pause) begin
                        state <= HOLD;
                    end else begin
                        // Leaving HOLD counts on the same edge, so a pause costs exactly one cycle per high sample.
                        state <= RUN;
                        if (count != 8'd0) begin
                            count <= count - 8'd1;
                        end else begin
                            expire <= 1'b1;
                            if (expire_count != 8'hFF) begin
                                expire_count <= expire_count + 8'd1;
                            end
                            if (reload_flag) begin
                                count <= period_m1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown8.sv
// Directed self-checking bench for countdown8. Expected values are hand-computed from the timing rules.
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
module tb_countdown8;

    logic       clk;
    logic       reset_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_value;
    logic       auto_reload;
    logic       pause;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       expire;
    logic [7:0] expire_count;

    int n_checks = 0;
    int n_fail   = 0;

    countdown8 #(.RELOAD_DEFAULT(1'b0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_value   (load_value),
        .auto_reload  (auto_reload),
        .pause        (pause),
        .abort        (abort),
        .count        (count),
        .busy         (busy),
        .expire       (expire),
        .expire_count (expire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one period and let it be accepted on the next edge.
    task automatic load(input logic [7:0] n, input logic reload);
        load_valid  = 1'b1;
        load_value  = n;
        auto_reload = reload;
        tick();
        load_valid  = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int last;
        int lows;
        int seen;

        reset_n     = 1'b0;
        load_valid  = 1'b0;
        load_value  = 8'd0;
        auto_reload = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_expire", expire, 0);
        check("rst_ready", load_ready, 1);
        check("rst_xcnt", expire_count, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // One-shot N=5: 4,3,2,1,0 then expire five edges after accept.
        load(8'd5, 1'b0);
        check("os_count0", count, 4);
        check("os_busy", busy, 1);
        check("os_ready_run", load_ready, 0);
        for (int i = 3; i >= 0; i--) begin
            tick();
            check("os_count", count, i);
            check("os_noexp", expire, 0);
        end
        tick();
        check("os_expire", expire, 1);
        check("os_ready", load_ready, 1);
        check("os_idle", busy, 0);
        check("os_xcnt", expire_count, 1);
        tick();
        check("os_pulse_end", expire, 0);

        // Periodic N=0: 256-cycle period, four pulses in 1024 cycles.
        load(8'd0, 1'b1);
        check("wrap_start", count, 255);
        pulses = 0;
        last   = -1;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            if (expire) begin
                pulses++;
                if (last < 0) check("wrap_first", i, 256);
                else          check("wrap_spacing", i - last, 256);
                last = i;
            end
        end
        check("wrap_pulses", pulses, 4);
        check("wrap_xcnt", expire_count, 4);
        do_abort();
        check("wrap_abort_busy", busy, 0);
        check("wrap_abort_xcnt", expire_count, 4);

        // Periodic N=1: expire held high every cycle, expire_count saturates.
        load(8'd1, 1'b1);
        check("n1_count", count, 0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!expire) lows++;
        end
        check("n1_always_high", lows, 0);
        check("n1_saturate", expire_count, 255);
        do_abort();
        check("n1_abort_count", count, 0);

        // Pause for three cycles at count=6: expiry 13 edges after accept.
        load(8'd10, 1'b0);
        tick();
        tick();
        tick();
        check("pz_at6", count, 6);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pz_hold", count, 6);
        end
        pause = 1'b0;
        seen = 0;
        for (int i = 7; i <= 20 && seen == 0; i++) begin
            tick();
            if (expire) seen = i;
        end
        check("pz_expire_at", seen, 13);

        // Pause at count=0 defers the expiry by two cycles.
        load(8'd4, 1'b0);
        tick();
        tick();
        tick();
        check("pz0_at0", count, 0);
        pause = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("pz0_noexp", expire, 0);
            check("pz0_busy", busy, 1);
        end
        pause = 1'b0;
        tick();
        check("pz0_expire", expire, 1);
        check("pz0_xcnt", expire_count, 1);

        // Abort at count=0 wins over expiry.
        load(8'd8, 1'b0);
        for (int k = 0; k < 7; k++) tick();
        check("ab_at0", count, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_noexp", expire, 0);
        check("ab_idle", busy, 0);
        check("ab_count", count, 0);
        check("ab_xcnt", expire_count, 0);

        // Load together with abort in IDLE is rejected.
        load_valid = 1'b1;
        load_value = 8'd9;
        abort      = 1'b1;
        tick();
        load_valid = 1'b0;
        abort      = 1'b0;
        check("ldab_busy", busy, 0);
        check("ldab_count", count, 0);

        // Offer held through a one-shot run is taken only the edge after expiry.
        load_valid  = 1'b1;
        load_value  = 8'd3;
        auto_reload = 1'b0;
        tick();
        check("hs_count0", count, 2);
        load_value = 8'd7;
        tick();
        check("hs_count1", count, 1);
        check("hs_ready_low", load_ready, 0);
        tick();
        check("hs_count2", count, 0);
        tick();
        check("hs_expire", expire, 1);
        check("hs_ready", load_ready, 1);
        check("hs_count_exp", count, 0);
        tick();
        load_valid = 1'b0;
        check("hs_reload", count, 6);
        check("hs_busy", busy, 1);
        check("hs_xcnt", expire_count, 0);
        do_abort();

        // Asynchronous reset mid-run at count=37.
        load(8'd50, 1'b0);
        for (int k = 0; k < 12; k++) tick();
        check("ar_at37", count, 37);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_busy", busy, 0);
        check("ar_expire", expire, 0);
        check("ar_ready", load_ready, 1);
        #2;
        reset_n = 1'b1;
        tick();
        check("ar_stay_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
